// File: rtl/id_exe_elastic_pkg.sv
// Shared encodings for the ID->EXE elastic stage: bubble instruction, load opcode,
// occupancy states and the default widths.
package id_exe_elastic_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_RDATA_W = 32;
    localparam int DEF_RADDR_W = 5;

    localparam logic [31:0] NOP_ENC  = 32'h0000_0013;
    localparam logic [6:0]  LOAD_ENC = 7'b0000011;

    // Encoding equals the number of held entries, so count_o is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/id_exe_elastic_entry.sv
// One payload register of the elastic stage: loads on enable, zeroes on clear.
module id_exe_entry #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i) begin
        if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_exe_elastic.sv
// ID->EXE pipeline stage with valid/ready handshake, 2-entry skid buffer,
// flush, bubble presentation and load-use hazard detection.
module id_exe_elastic
    import id_exe_elastic_pkg::*;
#(
    parameter int                  DATA_W   = DEF_DATA_W,
    parameter int                  ADDR_W   = DEF_ADDR_W,
    parameter int                  RDATA_W  = DEF_RDATA_W,
    parameter int                  RADDR_W  = DEF_RADDR_W,
    parameter logic [DATA_W-1:0]   NOP_INST = NOP_ENC,
    parameter logic [6:0]          LOAD_OPC = LOAD_ENC
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  inst_i,
    input  logic [ADDR_W-1:0]  inst_addr_i,
    input  logic [RDATA_W-1:0] op1_i,
    input  logic [RDATA_W-1:0] op2_i,
    input  logic               reg_we_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic [RADDR_W-1:0] id_rs1_i,
    input  logic [RADDR_W-1:0] id_rs2_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  inst_o,
    output logic [ADDR_W-1:0]  inst_addr_o,
    output logic [RDATA_W-1:0] op1_o,
    output logic [RDATA_W-1:0] op2_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               inst_is_load_o,
    output logic [RADDR_W-1:0] rd_o,
    output logic               load_use_o,
    output logic [1:0]         count_o
);

    typedef struct packed {
        logic [DATA_W-1:0]  inst;
        logic [ADDR_W-1:0]  addr;
        logic [RDATA_W-1:0] op1;
        logic [RDATA_W-1:0] op2;
        logic               reg_we;
        logic [RADDR_W-1:0] waddr;
        logic               is_load;
        logic [RADDR_W-1:0] rd;
    } payload_t;

    localparam int PW = $bits(payload_t);

    state_e   state_q, state_d;
    logic     in_ready_q;
    logic     accept, issue;
    logic     head_ld, skid_ld, head_from_skid;
    payload_t in_pl, head_d, head_q, skid_q;

    // Load sideband is decoded once on entry and travels with the payload.
    always_comb begin
        in_pl.inst    = inst_i;
        in_pl.addr    = inst_addr_i;
        in_pl.op1     = op1_i;
        in_pl.op2     = op2_i;
        in_pl.reg_we  = reg_we_i;
        in_pl.waddr   = reg_waddr_i;
        in_pl.is_load = (inst_i[6:0] == LOAD_OPC);
        in_pl.rd      = RADDR_W'(inst_i[11:7]);
    end

    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_ready_o  = in_ready_q;
    assign accept      = in_valid_i & in_ready_q;
    assign issue       = out_valid_o & out_ready_i;

    always_comb begin
        state_d        = state_q;
        head_ld        = 1'b0;
        skid_ld        = 1'b0;
        head_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    head_ld = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && issue) begin
                    head_ld = 1'b1;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_ld = 1'b1;
                end else if (issue) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (issue) begin
                    state_d        = ST_ONE;
                    head_ld        = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A kill wins over any transfer in the same cycle.
        if (flush_i) begin
            state_d = ST_EMPTY;
            head_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    // Ready is registered from the next occupancy to keep it off the combinational path.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    assign head_d = head_from_skid ? skid_q : in_pl;

    id_exe_entry #(.W(PW)) u_head (
        .clk_i (clk_i),
        .ld    (head_ld),
        .clr   (flush_i),
        .d     (head_d),
        .q     (head_q)
    );

    id_exe_entry #(.W(PW)) u_skid (
        .clk_i (clk_i),
        .ld    (skid_ld),
        .clr   (flush_i),
        .d     (in_pl),
        .q     (skid_q)
    );

    // Payload is never visible while the head is invalid.
    always_comb begin
        inst_o         = NOP_INST;
        inst_addr_o    = '0;
        op1_o          = '0;
        op2_o          = '0;
        reg_we_o       = 1'b0;
        reg_waddr_o    = '0;
        inst_is_load_o = 1'b0;
        rd_o           = '0;
        if (out_valid_o) begin
            inst_o         = head_q.inst;
            inst_addr_o    = head_q.addr;
            op1_o          = head_q.op1;
            op2_o          = head_q.op2;
            reg_we_o       = head_q.reg_we;
            reg_waddr_o    = head_q.waddr;
            inst_is_load_o = head_q.is_load;
            rd_o           = head_q.rd;
        end
    end

    assign load_use_o = out_valid_o & inst_is_load_o & (rd_o != '0) &
                        ((rd_o == id_rs1_i) | (rd_o == id_rs2_i));

    assign count_o = state_q;

endmodule
